// File: rtl/dot_seq_if.sv
// Element-stream and result-stream bundle between a producer/consumer and the dot_seq sequencer.
interface dot_seq_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [ACC_W-1:0]  res_data;
    logic                     res_err;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/dot_seq.sv
// Sequences K element pairs into an external mac and captures the accumulated dot product.
// IDLE: wait elt 0 | FEED: take elts 1..K-1 | DRAIN/FLUSH: mac pipeline empties | CAPTURE: latch acc | RESULT: hold until taken
module dot_seq #(
    parameter int DATA_W = 16,
    parameter int K      = 4,
    parameter int ACC_W  = 2*DATA_W+$clog2(K)+1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dot_seq_if.slave                 bus,
    output logic signed [DATA_W-1:0] o_mac_a,
    output logic signed [DATA_W-1:0] o_mac_b,
    output logic                     o_mac_acc_clear,
    input  logic                     i_mac_acc_out_valid,
    input  logic signed [ACC_W-1:0]  i_mac_acc_out
);

    localparam int IDX_W = $clog2(K);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K-1);

    typedef enum logic [2:0] {
        IDLE, FEED, DRAIN, FLUSH, CAPTURE, RESULT
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic signed [DATA_W-1:0] r_mac_a;
    logic signed [DATA_W-1:0] r_mac_b;
    logic                     r_e0_on_bus;
    logic                     r_acc_clear;
    logic                     r_res_valid;
    logic signed [ACC_W-1:0]  r_res_data;
    logic                     r_res_err;
    logic                     w_in_ready;
    logic                     w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = FEED;
            end
            FEED: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_idx == LAST_IDX)) w_state_nxt = DRAIN;
            end
            DRAIN:   w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = RESULT;
            RESULT:  if (bus.res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear follows element 0 by one bus cycle so the mac sees its product as the new base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_e0_on_bus <= 1'b0;
            r_acc_clear <= 1'b0;
        end else begin
            r_mac_a     <= w_accept ? bus.in_a : '0;
            r_mac_b     <= w_accept ? bus.in_b : '0;
            r_e0_on_bus <= w_accept && (r_idx == '0);
            r_acc_clear <= r_e0_on_bus;
            if (w_accept) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_res_valid <= 1'b1;
            r_res_data  <= i_mac_acc_out;
            r_res_err   <= ~i_mac_acc_out_valid;
        end else if ((r_state == RESULT) && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_data     = r_res_data;
    assign bus.res_err      = r_res_err;
    assign o_mac_a          = r_mac_a;
    assign o_mac_b          = r_mac_b;
    assign o_mac_acc_clear  = r_acc_clear;

endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 Parameter DATA_W, default 16, operand width in bits.
REQ-002 Parameter K, default 4, elements per dot product; K >= 2.
REQ-003 Parameter ACC_W, default 2*DATA_W+$clog2(K)+1, result width; must equal the mac instance ACC_W.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  element pair on in_a/in_b is valid.
REQ-007 in_ready  output  1  sequencer accepts an element this cycle.
REQ-008 in_a, in_b  input  DATA_W each  signed element pair.
REQ-009 mac_a, mac_b  output  DATA_W each  signed operands to mac a_in/b_in, registered.
REQ-010 mac_acc_clear  output  1  to mac acc_clear, registered.
REQ-011 mac_acc_out_valid  input  1  from mac acc_out_valid.
REQ-012 mac_acc_out  input  ACC_W  signed, from mac acc_out.
REQ-013 res_valid  output  1  dot-product result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_data  output  ACC_W  signed captured dot product.
REQ-016 res_err  output  1  mac_acc_out_valid was low at capture.

Function
REQ-017 States: IDLE, FEED, DRAIN, FLUSH, CAPTURE, RESULT.
REQ-018 Element accepted on a rising edge with in_valid && in_ready; in_ready = 1 in IDLE and FEED only.
REQ-019 Accepted element is driven on mac_a/mac_b for exactly the next cycle; any cycle without an accepted element in the preceding edge drives mac_a = mac_b = 0.
REQ-020 Element counter idx (0..K-1) counts accepted elements; IDLE -> FEED on acceptance of element 0.
REQ-021 mac_acc_clear = 1 for exactly one cycle: the cycle immediately after element 0 was on mac_a/mac_b, regardless of whether element 1 was accepted (stall presents zeros; product 0 is added harmlessly).
REQ-022 mac_acc_clear = 0 in all other cycles.
REQ-023 FEED -> DRAIN on acceptance of element K-1 (last element on mac bus during DRAIN).
REQ-024 DRAIN -> FLUSH -> CAPTURE unconditionally, one cycle each; mac bus zeros, clear low.
REQ-025 At the edge leaving CAPTURE: res_data <= mac_acc_out, res_err <= ~mac_acc_out_valid, res_valid <= 1; state -> RESULT.
REQ-026 Latency: res_valid rises 3 edges after the edge that accepted element K-1.
REQ-027 RESULT: res_valid, res_data, res_err held stable until res_valid && res_ready at an edge; then res_valid <= 0, state -> IDLE.
REQ-028 No element accepted in the RESULT-exit cycle; next vector may be accepted from the following cycle.
REQ-029 in_valid stalls in FEED are unbounded; result unaffected.
REQ-030 Arithmetic done entirely by the mac; sequencer performs no math; res_data passes full ACC_W without truncation.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, idx 0, mac_a = mac_b = 0, mac_acc_clear = 0, res_valid = 0, res_data = 0, res_err = 0.
REQ-032 in_ready = 1 in the first cycle after rst_n deasserts.
REQ-033 Reset mid-vector discards the partial vector; next accepted element is element 0 of a new vector.
REQ-034 The integrating level drives the mac reset from ~rst_n.

Verification
REQ-035 Stream [1,2,3,4]·[5,6,7,8], in_valid continuous -> clear high in cycle of element 1; res_valid 3 edges after last accept; res_data = 70, res_err = 0.
REQ-036 Back-to-back [-1,10,-20,3]·[2,-3,4,5] after 70 consumed -> res_data = -97; no carry-over from prior result.
REQ-037 Vector 1 with in_valid low for 3 cycles between element 0 and 1 and 2 cycles between 2 and 3 -> clear pulses once; res_data = 70.
REQ-038 res_ready low 5 cycles after result -> res_valid/res_data held, in_ready = 0; accept on 6th cycle -> IDLE, in_ready = 1.
REQ-039 All elements -32768·-32768 -> res_data = 4294967296 (no overflow in ACC_W = 35).
REQ-040 rst_n low after element 2 accepted, then full vector [1,1,1,1]·[2,2,2,2] -> res_data = 8, single clear pulse.
